// File: rtl/html_char_streamer.sv
// html_char_streamer: streams a ROM-held HTML document, one dwell-timed char at a time, into a parser.
// Optional `WS_COLLAPSE_EN folds CR/LF/TAB to space and drops redundant whitespace before it reaches the FIFO.
module html_char_streamer #(
  parameter int ADDR_W    = 12,
  parameter int DOC_LEN   = 4096,
  parameter int MIN_DWELL = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        char,
  output logic              state_enable,
  output logic              done
);
  localparam int DW = $clog2(MIN_DWELL + 1) + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DOC_LEN - 1);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] mem_q [4];
  logic [1:0] rp_q, rp_d, wp_q, wp_d;
  logic [2:0] cnt_q, cnt_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [7:0] char_q, char_d, byte_c;
  logic rd_q, rd_d, rd_last_q, rd_last_d, stop_q, stop_d, have_q, have_d, stall_q, stall_d;
  logic active, acc, dwell_ok, adv, issue, eod, push, pop, stall_now, finish, clr, skip;
  assign active = state_q == STREAM || state_q == DRAIN;
  assign acc = start && (state_q == IDLE || state_q == DONE);
  assign dwell_ok = dwell_q >= DW'(MIN_DWELL);
  assign adv = !pause && (!have_q || dwell_ok);
  assign issue = state_q == STREAM && !stop_q && (cnt_q + {2'b0, rd_q}) < 3'd4;
  assign eod = state_q == STREAM && rd_q && (rom_data == 8'h00 || rd_last_q);
  assign push = state_q == STREAM && rd_q && rom_data != 8'h00 && !skip;
  assign pop = active && cnt_q != 3'd0 && adv;
  assign stall_now = state_q == STREAM && have_q && adv && cnt_q == 3'd0;
  assign finish = state_q == DRAIN && cnt_q == 3'd0 && adv;
  assign clr = acc || finish;
`ifdef WS_COLLAPSE_EN
  logic [7:0] last_q;
  always_ff @(posedge clock)
    if (reset || acc) last_q <= '0;
    else if (push) last_q <= byte_c;
  assign byte_c = (rom_data == 8'h0D || rom_data == 8'h0A || rom_data == 8'h09) ? 8'h20 : rom_data;
  assign skip = byte_c == 8'h20 && (last_q == 8'h20 || last_q == 8'h3E);
`else
  assign byte_c = rom_data;
  assign skip = 1'b0;
`endif
  // Reads returning after leaving STREAM (speculative ones past the terminator) are simply never consumed.
  always_comb begin
    state_d = acc ? STREAM : eod ? DRAIN : finish ? DONE : state_q;
    addr_d = clr ? '0 : (issue && addr_q != LAST) ? addr_q + ADDR_W'(1) : addr_q;
    rd_d = !clr && issue;
    rd_last_d = !clr && issue && addr_q == LAST;
    stop_d = !clr && (stop_q || rd_last_d);
    wp_d = clr ? '0 : wp_q + {1'b0, push};
    rp_d = clr ? '0 : rp_q + {1'b0, pop};
    cnt_d = clr ? '0 : cnt_q + {2'b0, push} - {2'b0, pop};
    char_d = clr ? '0 : pop ? mem_q[rp_q] : char_q;
    have_d = !clr && (have_q || pop);
    dwell_d = clr ? '0 : pop ? DW'(1) : dwell_ok ? dwell_q : dwell_q + DW'(1);
    stall_d = !clr && !pop && (stall_q || stall_now);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      rd_q <= 1'b0;
      rd_last_q <= 1'b0;
      stop_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      char_q <= '0;
      have_q <= 1'b0;
      dwell_q <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rd_q <= rd_d;
      rd_last_q <= rd_last_d;
      stop_q <= stop_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      char_q <= char_d;
      have_q <= have_d;
      dwell_q <= dwell_d;
      stall_q <= stall_d;
    end
  end
  always_ff @(posedge clock)
    if (push) mem_q[wp_q] <= byte_c;
  // Enable stays low from the stall until the refilled char is actually on the bus.
  assign rom_addr = addr_q;
  assign char = char_q;
  assign state_enable = active && have_q && !stall_now && !stall_q;
  assign done = state_q == DONE;
endmodule
